// File: rtl/inter1_obuf.sv
// Ping-pong output buffer behind the first-stage interleaver.
// Two banks hold whole frames of 4-lane vectors. One bank fills from the
// interleaver while the other streams out one lane word per cycle.
module inter1_obuf #(
  parameter int unsigned W     = 30,
  parameter int unsigned DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [W-1:0] z1_1,
  input  logic [W-1:0] z1_2,
  input  logic [W-1:0] z1_3,
  input  logic [W-1:0] z1_4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic {StIdle, StStream} state_e;

  // Vector storage, addressed {bank, vector index}; lane 1 sits in the low bits.
  logic [4*W-1:0] mem_q [2*DEPTH];

  logic [1:0]    full_q, full_d;
  // Index of the final vector of each stored frame (length minus one).
  logic [AW-1:0] last_q [2];
  logic [AW-1:0] last_d [2];
  logic          wb_q, wb_d;
  logic [AW-1:0] wcnt_q, wcnt_d;

  state_e        state_q, state_d;
  logic          rb_q, rb_d;
  logic [AW-1:0] rv_q, rv_d;
  logic [1:0]    rl_q, rl_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          accept, close, rd_free, last_word;
  logic [AW-1:0] nxt_rv, rd_rv;
  logic [1:0]    nxt_rl, rd_rl;
  logic [4*W-1:0] rd_vec;
  logic [W-1:0]  rd_word;

  assign in_ready  = !full_q[wb_q];
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || (wcnt_q == LastIdx));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // Address of the word loaded next: word 0 from idle, otherwise the successor.
  assign nxt_rl    = rl_q + 2'd1;
  assign nxt_rv    = (rl_q == 2'd3) ? rv_q + AW'(1) : rv_q;
  assign rd_rv     = (state_q == StIdle) ? '0 : nxt_rv;
  assign rd_rl     = (state_q == StIdle) ? 2'd0 : nxt_rl;
  assign rd_vec    = mem_q[{rb_q, rd_rv}];
  assign last_word = (rv_q == last_q[rb_q]) && (rl_q == 2'd3);

  // Lane select of the word being loaded.
  always_comb begin
    rd_word = rd_vec[W-1:0];
    case (rd_rl)
      2'd0:    rd_word = rd_vec[W-1:0];
      2'd1:    rd_word = rd_vec[2*W-1:W];
      2'd2:    rd_word = rd_vec[3*W-1:2*W];
      default: rd_word = rd_vec[4*W-1:3*W];
    endcase
  end

  // Bank contents are not reset; the full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[{wb_q, wcnt_q}] <= {z1_4, z1_3, z1_2, z1_1};
  end

  // Write side: count vectors, close frames on in_last or a full bank.
  always_comb begin
    full_d = full_q;
    last_d = last_q;
    wb_d   = wb_q;
    wcnt_d = wcnt_q;
    // Free and close always hit different banks.
    if (rd_free) full_d[rb_q] = 1'b0;
    if (accept) begin
      if (close) begin
        full_d[wb_q] = 1'b1;
        last_d[wb_q] = wcnt_q;
        wcnt_d       = '0;
        wb_d         = ~wb_q;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end
  end

  // Read FSM: load the first word from idle, then step lanes and vectors.
  always_comb begin
    state_d     = state_q;
    rb_d        = rb_q;
    rv_d        = rv_q;
    rl_d        = rl_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_free     = 1'b0;
    case (state_q)
      StIdle: begin
        if (full_q[rb_q]) begin
          out_data_d  = rd_word;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          rv_d        = '0;
          rl_d        = 2'd0;
          state_d     = StStream;
        end
      end
      StStream: begin
        if (out_valid_q && out_ready) begin
          if (last_word) begin
            rd_free     = 1'b1;
            rb_d        = ~rb_q;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = StIdle;
          end else begin
            rv_d       = nxt_rv;
            rl_d       = nxt_rl;
            out_data_d = rd_word;
            out_last_d = (nxt_rv == last_q[rb_q]) && (nxt_rl == 2'd3);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards partial and unsent frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= '0;
      last_q[0]   <= '0;
      last_q[1]   <= '0;
      wb_q        <= 1'b0;
      wcnt_q      <= '0;
      state_q     <= StIdle;
      rb_q        <= 1'b0;
      rv_q        <= '0;
      rl_q        <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      last_q      <= last_d;
      wb_q        <= wb_d;
      wcnt_q      <= wcnt_d;
      state_q     <= state_d;
      rb_q        <= rb_d;
      rv_q        <= rv_d;
      rl_q        <= rl_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_inter1_obuf.sv
// Directed bench for inter1_obuf: one DEPTH=64 instance and one DEPTH=4
// instance for the auto-close case.
module tb_inter1_obuf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=64 instance
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [29:0] z1, z2, z3, z4, out_data;
  // DEPTH=4 instance
  logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4, out_last4;
  logic [29:0] y1, y2, y3, y4, out_data4;

  int n_checks = 0;
  int n_pass   = 0;

  inter1_obuf #(.W(30), .DEPTH(64)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .z1_1(z1), .z1_2(z2), .z1_3(z3), .z1_4(z4), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  inter1_obuf #(.W(30), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_last(in_last4),
    .z1_1(y1), .z1_2(y2), .z1_3(y3), .z1_4(y4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4)
  );

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_last4 = 1'b0; out_ready4 = 1'b0;
    z1 = '0; z2 = '0; z3 = '0; z4 = '0;
    y1 = '0; y2 = '0; y3 = '0; y4 = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Presents one vector and returns 1 ns after the edge that accepted it.
  task automatic send_vec(input int a, input int b, input int c, input int d,
                          input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_last = last;
    z1 = 30'(a); z2 = 30'(b); z3 = 30'(c); z4 = 30'(d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_vec timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic send_vec4(input int a, input logic last);
    bit ok = 0;
    in_valid4 = 1'b1; in_last4 = last;
    y1 = 30'(a); y2 = 30'(a + 1); y3 = 30'(a + 2); y4 = 30'(a + 3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready4) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 in_valid4 = 1'b0; in_last4 = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_vec4 timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  // Both banks full and a word on the output, then reset between edges.
  task automatic test_reset();
    do_reset();
    send_vec(11, 12, 13, 14, 1'b1);
    send_vec(21, 22, 23, 24, 1'b1);
    #2;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_pre_in_ready: got %b required 0", in_ready);
    else n_pass++;
    n_checks++;
    if (out_data !== 30'd11) $display("FAIL reset_pre_data: got %0d required 11", out_data);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b required 0", out_last);
    else n_pass++;
    n_checks++;
    if (out_data !== 30'd0) $display("FAIL reset_out_data: got %0d required 0", out_data);
    else n_pass++;
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    send_vec(1, 2, 3, 4, 1'b0);
    send_vec(5, 6, 7, 8, 1'b0);
    send_vec(9, 10, 11, 12, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_latency: out_valid %b at close, required 0", out_valid);
    else n_pass++;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 30'(i + 1))
        $display("FAIL single_word[%0d]: valid %b data %0d, required 1 and %0d",
                 i, out_valid, out_data, i + 1);
      else n_pass++;
      n_checks++;
      if (out_last !== (i == 11))
        $display("FAIL single_last[%0d]: got %b required %b", i, out_last, i == 11);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL single_end: out_valid %b required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    send_vec(1, 2, 3, 4, 1'b0);
    send_vec(5, 6, 7, 8, 1'b0);
    send_vec(9, 10, 11, 12, 1'b1);
    for (int k = 0; k < 100 && n < 12; k++) begin
      out_ready = (k % 3 == 0);
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (out_data !== 30'(n + 1))
          $display("FAIL bp_word[%0d]: got %0d required %0d", n, out_data, n + 1);
        else n_pass++;
        n_checks++;
        if (out_last !== (n == 11))
          $display("FAIL bp_last[%0d]: got %b required %b", n, out_last, n == 11);
        else n_pass++;
        if (out_ready) n++;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (n != 12) $display("FAIL bp_count: got %0d words required 12", n);
    else n_pass++;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_extra: out_valid %b required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_vec(1, 2, 3, 4, 1'b0);
    send_vec(5, 6, 7, 8, 1'b1);
    send_vec(9, 10, 11, 12, 1'b0);
    send_vec(13, 14, 15, 16, 1'b1);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL pp_stall: in_ready %b required 0", in_ready);
    else n_pass++;
    out_ready = 1'b1;
    fork
      begin
        send_vec(17, 18, 19, 20, 1'b0);
        send_vec(21, 22, 23, 24, 1'b1);
      end
      begin
        for (int c = 0; c < 26; c++) begin
          int  exp_d;
          bit  idle;
          idle  = (c == 8) || (c == 17);
          exp_d = c + 1 - ((c > 8) ? 1 : 0) - ((c > 17) ? 1 : 0);
          @(negedge clk);
          n_checks++;
          if (out_valid !== !idle)
            $display("FAIL pp_valid[%0d]: got %b required %b", c, out_valid, !idle);
          else n_pass++;
          if (!idle) begin
            n_checks++;
            if (out_data !== 30'(exp_d) || out_last !== (exp_d % 8 == 0))
              $display("FAIL pp_word[%0d]: data %0d last %b, required %0d and %b",
                       c, out_data, out_last, exp_d, exp_d % 8 == 0);
            else n_pass++;
          end
          if (c == 7 || c == 8) begin
            n_checks++;
            if (in_ready !== (c == 8))
              $display("FAIL pp_in_ready[%0d]: got %b required %b", c, in_ready, c == 8);
            else n_pass++;
          end
        end
      end
    join
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL pp_end: out_valid %b required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_autoclose();
    int n = 0;
    int cyc[24];
    do_reset();
    out_ready4 = 1'b1;
    fork
      begin
        for (int v = 0; v < 6; v++) send_vec4(4 * v + 1, v == 5);
      end
      begin
        for (int k = 0; k < 80 && n < 24; k++) begin
          @(negedge clk);
          if (out_valid4) begin
            cyc[n] = k;
            n_checks++;
            if (out_data4 !== 30'(n + 1))
              $display("FAIL ac_word[%0d]: got %0d required %0d", n, out_data4, n + 1);
            else n_pass++;
            n_checks++;
            if (out_last4 !== (n == 15 || n == 23))
              $display("FAIL ac_last[%0d]: got %b required %b", n, out_last4,
                       n == 15 || n == 23);
            else n_pass++;
            n++;
          end
        end
      end
    join
    n_checks++;
    if (n != 24) $display("FAIL ac_count: got %0d words required 24", n);
    else n_pass++;
    if (n == 24) begin
      n_checks++;
      if (cyc[15] - cyc[0] != 15 || cyc[16] - cyc[15] != 2)
        $display("FAIL ac_timing: frame span %0d gap %0d, required 15 and 2",
                 cyc[15] - cyc[0], cyc[16] - cyc[15]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    send_vec(1, 2, 3, 4, 1'b0);
    send_vec(5, 6, 7, 8, 1'b0);
    send_vec(9, 10, 11, 12, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 30'd5)
      $display("FAIL mid_word5: valid %b data %0d, required 1 and 5", out_valid, out_data);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 30'd0 || out_last !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_reset: valid %b data %0d last %b ready %b, required 0 0 0 1",
               out_valid, out_data, out_last, in_ready);
    else n_pass++;
    #1 rst = 1'b0;
    send_vec(101, 102, 103, 104, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (out_data !== 30'(101 + n) || out_last !== (n == 3))
          $display("FAIL mid_word[%0d]: data %0d last %b, required %0d and %b",
                   n, out_data, out_last, 101 + n, n == 3);
        else n_pass++;
        n++;
      end
    end
    n_checks++;
    if (n != 4) $display("FAIL mid_count: got %0d words required 4", n);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_autoclose();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
